// File: rtl/pc_stack_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pc_stack_unit
// Purpose  : Program counter with increment, absolute and PC-relative jumps,
//            subroutine call/return through a hardware return-address stack,
//            a stall input and sticky stack overflow/underflow flags.
// Ports    : Clock, Resetn (async, active-low)
//            BusWires    - jump target or signed relative offset
//            stall       - freeze pc, stack and flags (clr_err still honoured)
//            pc_incr, pc_in, pc_rel, pc_call, pc_ret - command strobes
//            clr_err     - clear sticky error flags
//            pc          - current program counter
//            sp          - number of valid stack entries
//            stack_full, stack_empty, stack_ovf, stack_unf - stack status
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module pc_stack_unit #(
   parameter int             W         = 16,
   parameter int             DEPTH     = 4,
   parameter logic [W-1:0]   RESET_VEC = '0
) (
   input  logic                         Clock,
   input  logic                         Resetn,
   input  logic [W-1:0]                 BusWires,
   input  logic                         stall,
   input  logic                         pc_incr,
   input  logic                         pc_in,
   input  logic                         pc_rel,
   input  logic                         pc_call,
   input  logic                         pc_ret,
   input  logic                         clr_err,
   output logic [W-1:0]                 pc,
   output logic [$clog2(DEPTH+1)-1:0]   sp,
   output logic                         stack_full,
   output logic                         stack_empty,
   output logic                         stack_ovf,
   output logic                         stack_unf
);

   localparam int                 c_SPW      = $clog2(DEPTH + 1);
   localparam int                 c_IW       = $clog2(DEPTH);
   localparam logic [c_SPW-1:0]   c_SP_ONE   = c_SPW'(1);
   localparam logic [c_SPW-1:0]   c_SP_DEPTH = c_SPW'(DEPTH);
   localparam logic [W-1:0]       c_PC_ONE   = W'(1);

   logic [W-1:0]       r_pc;
   logic [c_SPW-1:0]   r_sp;
   logic               r_ovf;
   logic               r_unf;
   logic [W-1:0]       r_stack [DEPTH];

   logic [W-1:0]       w_pc_plus1;
   logic [W-1:0]       w_pc_nxt;
   logic [c_SPW-1:0]   w_sp_dec;
   logic [c_SPW-1:0]   w_sp_nxt;
   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_ovf_set;
   logic               w_unf_set;

   assign w_pc_plus1 = r_pc + c_PC_ONE;
   assign w_sp_dec   = r_sp - c_SP_ONE;
   assign w_full     = (r_sp == c_SP_DEPTH);
   assign w_empty    = (r_sp == '0);

   // Priority chain: stall > ret > call > in > rel > incr > hold.
   always_comb begin
      w_pc_nxt  = r_pc;
      w_sp_nxt  = r_sp;
      w_push    = 1'b0;
      w_ovf_set = 1'b0;
      w_unf_set = 1'b0;
      if (!stall) begin
         if (pc_ret) begin
            if (!w_empty) begin
               w_pc_nxt = r_stack[w_sp_dec[c_IW-1:0]];
               w_sp_nxt = w_sp_dec;
            end else begin
               // Return with nothing on the stack behaves as a no-op instruction.
               w_pc_nxt  = w_pc_plus1;
               w_unf_set = 1'b1;
            end
         end else if (pc_call) begin
            // The jump is taken even when the push is refused.
            w_pc_nxt = BusWires;
            if (!w_full) begin
               w_push   = 1'b1;
               w_sp_nxt = r_sp + c_SP_ONE;
            end else begin
               w_ovf_set = 1'b1;
            end
         end else if (pc_in) begin
            w_pc_nxt = BusWires;
         end else if (pc_rel) begin
            // Modulo-2^W add makes an unsigned add equal to a signed offset.
            w_pc_nxt = r_pc + BusWires;
         end else if (pc_incr) begin
            w_pc_nxt = w_pc_plus1;
         end
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_pc  <= RESET_VEC;
         r_sp  <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         r_pc <= w_pc_nxt;
         r_sp <= w_sp_nxt;
         // A new error in the same cycle as clr_err leaves the flag set.
         if (w_ovf_set)
            r_ovf <= 1'b1;
         else if (clr_err)
            r_ovf <= 1'b0;
         if (w_unf_set)
            r_unf <= 1'b1;
         else if (clr_err)
            r_unf <= 1'b0;
      end
   end

   // Stack contents are don't-care after reset, so the array carries no reset.
   always_ff @(posedge Clock) begin
      if (w_push)
         r_stack[r_sp[c_IW-1:0]] <= w_pc_plus1;
   end

   assign pc          = r_pc;
   assign sp          = r_sp;
   assign stack_full  = w_full;
   assign stack_empty = w_empty;
   assign stack_ovf   = r_ovf;
   assign stack_unf   = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_pc_stack_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_pc_stack_unit
// Purpose  : Self-checking bench for pc_stack_unit: directed vector table,
//            asynchronous reset sequence and randomized commands compared
//            against a queue-based reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_pc_stack_unit;

   localparam int W     = 16;
   localparam int DEPTH = 4;

   logic          Clock;
   logic          Resetn;
   logic [W-1:0]  BusWires;
   logic          stall, pc_incr, pc_in, pc_rel, pc_call, pc_ret, clr_err;
   logic [W-1:0]  pc;
   logic [2:0]    sp;
   logic          stack_full, stack_empty, stack_ovf, stack_unf;

   int checks   = 0;
   int failures = 0;

   pc_stack_unit #(.W(W), .DEPTH(DEPTH), .RESET_VEC(16'h0000)) dut (
      .Clock       (Clock),
      .Resetn      (Resetn),
      .BusWires    (BusWires),
      .stall       (stall),
      .pc_incr     (pc_incr),
      .pc_in       (pc_in),
      .pc_rel      (pc_rel),
      .pc_call     (pc_call),
      .pc_ret      (pc_ret),
      .clr_err     (clr_err),
      .pc          (pc),
      .sp          (sp),
      .stack_full  (stack_full),
      .stack_empty (stack_empty),
      .stack_ovf   (stack_ovf),
      .stack_unf   (stack_unf)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      logic          st, rt, cl, jn, rl, inc, cr;
      logic [W-1:0]  bus;
      logic [W-1:0]  epc;
      int            esp;
      logic          eovf, eunf;
   } vec_t;

   vec_t vecs[$];

   // Reference model state
   logic [W-1:0]  m_pc;
   logic [W-1:0]  m_stk[$];
   logic          m_ovf, m_unf;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_state(input string tag, input logic [W-1:0] epc, input int esp,
                            input logic eovf, input logic eunf);
      chk({tag, ".pc"}, 32'(pc), 32'(epc));
      chk({tag, ".sp"}, 32'(sp), 32'(esp));
      chk({tag, ".full"}, 32'(stack_full), 32'(esp == DEPTH));
      chk({tag, ".empty"}, 32'(stack_empty), 32'(esp == 0));
      chk({tag, ".ovf"}, 32'(stack_ovf), 32'(eovf));
      chk({tag, ".unf"}, 32'(stack_unf), 32'(eunf));
   endtask

   task automatic drive(input logic st, rt, cl, jn, rl, inc, cr, input logic [W-1:0] bus);
      @(negedge Clock);
      stall = st; pc_ret = rt; pc_call = cl; pc_in = jn;
      pc_rel = rl; pc_incr = inc; clr_err = cr; BusWires = bus;
      @(posedge Clock);
      #1;
   endtask

   task automatic idle();
      stall = 0; pc_ret = 0; pc_call = 0; pc_in = 0;
      pc_rel = 0; pc_incr = 0; clr_err = 0; BusWires = '0;
   endtask

   task automatic do_reset();
      @(negedge Clock);
      idle();
      Resetn = 1'b0;
      @(negedge Clock);
      @(negedge Clock);
      Resetn = 1'b1;
      m_pc = '0; m_stk.delete(); m_ovf = 0; m_unf = 0;
   endtask

   function automatic vec_t mk(input logic st, rt, cl, jn, rl, inc, cr,
                               input logic [W-1:0] bus, input logic [W-1:0] epc,
                               input int esp, input logic eovf, input logic eunf);
      vec_t v;
      v.st = st; v.rt = rt; v.cl = cl; v.jn = jn; v.rl = rl; v.inc = inc; v.cr = cr;
      v.bus = bus; v.epc = epc; v.esp = esp; v.eovf = eovf; v.eunf = eunf;
      return v;
   endfunction

   // Model one clock edge from the command rules, using a queue as the stack.
   task automatic model_step(input logic st, rt, cl, jn, rl, inc, cr, input logic [W-1:0] bus);
      logic ovf_new, unf_new;
      ovf_new = 0; unf_new = 0;
      if (!st) begin
         if (rt) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin m_pc = m_pc + 16'd1; unf_new = 1; end
         end else if (cl) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(m_pc + 16'd1);
            else ovf_new = 1;
            m_pc = bus;
         end else if (jn)  m_pc = bus;
         else if (rl)      m_pc = m_pc + bus;
         else if (inc)     m_pc = m_pc + 16'd1;
      end
      if (ovf_new) m_ovf = 1; else if (cr) m_ovf = 0;
      if (unf_new) m_unf = 1; else if (cr) m_unf = 0;
   endtask

   initial begin
      Resetn = 1'b1;
      idle();
      m_pc = '0; m_ovf = 0; m_unf = 0;

      //           st rt cl jn rl in cr  bus        pc         sp ovf unf
      vecs.push_back(mk(0,0,0,0,0,1,0, 16'h0000, 16'h0001, 0, 0, 0));
      vecs.push_back(mk(0,0,0,0,0,1,0, 16'h0000, 16'h0002, 0, 0, 0));
      vecs.push_back(mk(0,0,0,0,0,1,0, 16'h0000, 16'h0003, 0, 0, 0));
      vecs.push_back(mk(0,0,0,1,0,0,0, 16'hFFFF, 16'hFFFF, 0, 0, 0));
      vecs.push_back(mk(0,0,0,0,0,1,0, 16'h0000, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(0,0,0,1,0,0,0, 16'h0010, 16'h0010, 0, 0, 0));
      vecs.push_back(mk(0,0,0,0,1,0,0, 16'hFFFC, 16'h000C, 0, 0, 0));
      vecs.push_back(mk(0,0,0,1,0,0,0, 16'h0005, 16'h0005, 0, 0, 0));
      vecs.push_back(mk(0,0,1,0,0,0,0, 16'h0100, 16'h0100, 1, 0, 0));
      vecs.push_back(mk(0,0,0,0,0,1,0, 16'h0000, 16'h0101, 1, 0, 0));
      vecs.push_back(mk(0,0,1,0,0,0,0, 16'h0200, 16'h0200, 2, 0, 0));
      vecs.push_back(mk(0,1,0,0,0,0,0, 16'h0000, 16'h0102, 1, 0, 0));
      vecs.push_back(mk(0,1,0,0,0,0,0, 16'h0000, 16'h0006, 0, 0, 0));
      vecs.push_back(mk(0,0,1,0,0,0,0, 16'h1000, 16'h1000, 1, 0, 0));
      vecs.push_back(mk(0,0,1,0,0,0,0, 16'h2000, 16'h2000, 2, 0, 0));
      vecs.push_back(mk(0,0,1,0,0,0,0, 16'h3000, 16'h3000, 3, 0, 0));
      vecs.push_back(mk(0,0,1,0,0,0,0, 16'h4000, 16'h4000, 4, 0, 0));
      vecs.push_back(mk(0,0,1,0,0,0,0, 16'h5000, 16'h5000, 4, 1, 0));
      vecs.push_back(mk(1,0,1,0,0,0,0, 16'h6000, 16'h5000, 4, 1, 0));
      vecs.push_back(mk(0,1,0,0,0,0,0, 16'h0000, 16'h3001, 3, 1, 0));
      vecs.push_back(mk(0,1,0,0,0,0,0, 16'h0000, 16'h2001, 2, 1, 0));
      vecs.push_back(mk(0,1,0,0,0,0,0, 16'h0000, 16'h1001, 1, 1, 0));
      vecs.push_back(mk(0,1,0,0,0,0,0, 16'h0000, 16'h0007, 0, 1, 0));
      vecs.push_back(mk(0,1,0,0,0,0,0, 16'h0000, 16'h0008, 0, 1, 1));
      vecs.push_back(mk(0,0,0,0,0,0,1, 16'h0000, 16'h0008, 0, 0, 0));
      vecs.push_back(mk(0,0,0,1,0,0,0, 16'h003F, 16'h003F, 0, 0, 0));
      vecs.push_back(mk(0,0,1,0,0,0,0, 16'h0500, 16'h0500, 1, 0, 0));
      vecs.push_back(mk(0,1,1,0,0,1,0, 16'h0777, 16'h0040, 0, 0, 0));
      vecs.push_back(mk(0,1,0,0,0,0,1, 16'h0000, 16'h0041, 0, 0, 1));
      vecs.push_back(mk(1,0,0,0,0,1,1, 16'h0000, 16'h0041, 0, 0, 0));
      vecs.push_back(mk(0,0,0,0,1,1,0, 16'h0005, 16'h0046, 0, 0, 0));
      vecs.push_back(mk(0,0,0,0,0,0,0, 16'h1111, 16'h0046, 0, 0, 0));

      do_reset();
      #1;
      chk_state("reset", 16'h0000, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].st, vecs[i].rt, vecs[i].cl, vecs[i].jn, vecs[i].rl,
               vecs[i].inc, vecs[i].cr, vecs[i].bus);
         chk_state($sformatf("vec%0d", i), vecs[i].epc, vecs[i].esp, vecs[i].eovf, vecs[i].eunf);
      end

      // Asynchronous reset mid-cycle with sp=3, pc=1234 and a sticky flag set.
      do_reset();
      drive(0,1,0,0,0,0,0, 16'h0000);
      drive(0,0,1,0,0,0,0, 16'h0010);
      drive(0,0,1,0,0,0,0, 16'h0020);
      drive(0,0,1,0,0,0,0, 16'h0030);
      drive(0,0,0,1,0,0,0, 16'h1234);
      chk_state("pre_areset", 16'h1234, 3, 0, 1);
      @(negedge Clock);
      idle();
      pc_call = 1'b1; BusWires = 16'hBEEF;
      #2;
      Resetn = 1'b0;
      #1;
      chk_state("areset_now", 16'h0000, 0, 0, 0);
      @(negedge Clock);
      idle();
      Resetn = 1'b1;
      drive(0,0,0,0,0,1,0, 16'h0000);
      chk_state("areset_resume", 16'h0001, 0, 0, 0);

      // Randomized commands against the reference model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         logic st, rt, cl, jn, rl, inc, cr;
         logic [W-1:0] bus;
         st  = ($urandom_range(0, 9) == 0);
         rt  = ($urandom_range(0, 3) == 0);
         cl  = ($urandom_range(0, 2) == 0);
         jn  = ($urandom_range(0, 5) == 0);
         rl  = ($urandom_range(0, 4) == 0);
         inc = ($urandom_range(0, 1) == 0);
         cr  = ($urandom_range(0, 11) == 0);
         bus = 16'($urandom);
         drive(st, rt, cl, jn, rl, inc, cr, bus);
         model_step(st, rt, cl, jn, rl, inc, cr, bus);
         chk_state($sformatf("rand%0d", n), m_pc, m_stk.size(), m_ovf, m_unf);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
